// File: rtl/ddr_arbiter_mister.sv
// N-channel single-beat arbiter in front of the MiSTer DDRAM Avalon port.
// Define DDR_ARB_ROUND_ROBIN_EN for round-robin grant; otherwise lowest index wins.
module ddr_arbiter_mister #(
    parameter int NCH = 4,
    parameter int AW  = 29,
    parameter int DW  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH-1:0]    ch_write,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH*DW-1:0] ch_wdata,
    input  logic [NCH*8-1:0]  ch_be,
    output logic [NCH-1:0]    ch_ready,
    output logic [NCH-1:0]    ch_done,
    output logic [DW-1:0]     ch_rdata,
    output logic              DDRAM_CLK,
    input  logic              DDRAM_BUSY,
    output logic [7:0]        DDRAM_BURSTCNT,
    output logic [AW-1:0]     DDRAM_ADDR,
    input  logic [DW-1:0]     DDRAM_DOUT,
    input  logic              DDRAM_DOUT_READY,
    output logic              DDRAM_RD,
    output logic [DW-1:0]     DDRAM_DIN,
    output logic [7:0]        DDRAM_BE,
    output logic              DDRAM_WE
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

    state_t           r_state;
    logic [NCH-1:0]   r_grant;
    logic [NCH-1:0]   r_ready;
    logic [NCH-1:0]   r_done;
    logic             r_rd;
    logic             r_we;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_din;
    logic [7:0]       r_be;
    logic [DW-1:0]    r_rdata;

    logic [NCH-1:0]   w_win_oh;
    logic [AW-1:0]    w_addr;
    logic [DW-1:0]    w_wdata;
    logic [7:0]       w_be;
    logic             w_write;

`ifdef DDR_ARB_ROUND_ROBIN_EN
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    logic [PW-1:0]    r_last;
    logic [PW-1:0]    w_win_idx;
    int               w_best;

    // Winner is the requester at the smallest rotational distance past the last grant.
    always_comb begin
        w_win_idx = '0;
        w_best    = NCH;
        w_win_oh  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_req[i] && (((i - int'(r_last) - 1 + 2*NCH) % NCH) < w_best)) begin
                w_best    = (i - int'(r_last) - 1 + 2*NCH) % NCH;
                w_win_idx = PW'(i);
            end
        end
        for (int i = 0; i < NCH; i++) begin
            w_win_oh[i] = ch_req[i] && (w_win_idx == PW'(i));
        end
    end
`else
    always_comb begin
        w_win_oh = '0;
        for (int i = NCH-1; i >= 0; i--) begin
            if (ch_req[i]) begin
                w_win_oh    = '0;
                w_win_oh[i] = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_be    = '0;
        w_write = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (w_win_oh[i]) begin
                w_addr  = ch_addr[i*AW +: AW];
                w_wdata = ch_wdata[i*DW +: DW];
                w_be    = ch_be[i*8 +: 8];
                w_write = ch_write[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ready <= '0;
            r_done  <= '0;
            r_rd    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
            r_be    <= '0;
            r_rdata <= '0;
`ifdef DDR_ARB_ROUND_ROBIN_EN
            r_last  <= PW'(NCH-1);
`endif
        end else begin
            r_ready <= '0;
            r_done  <= '0;
            case (r_state)
                IDLE: begin
                    if (|ch_req) begin
                        r_grant <= w_win_oh;
                        r_ready <= w_win_oh;
                        r_addr  <= w_addr;
                        r_din   <= w_wdata;
                        r_be    <= w_be;
                        r_we    <= w_write;
                        r_rd    <= !w_write;
`ifdef DDR_ARB_ROUND_ROBIN_EN
                        r_last  <= w_win_idx;
`endif
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!DDRAM_BUSY) begin
                        r_rd <= 1'b0;
                        r_we <= 1'b0;
                        if (r_we) begin
                            r_done  <= r_grant;
                            r_state <= DONE;
                        end else begin
                            r_state <= WAIT_RD;
                        end
                    end
                end
                WAIT_RD: begin
                    if (DDRAM_DOUT_READY) begin
                        r_rdata <= DDRAM_DOUT;
                        r_done  <= r_grant;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ch_ready       = r_ready;
    assign ch_done        = r_done;
    assign ch_rdata       = r_rdata;
    assign DDRAM_CLK      = clk;
    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_ADDR     = r_addr;
    assign DDRAM_RD       = r_rd;
    assign DDRAM_DIN      = r_din;
    assign DDRAM_BE       = r_be;
    assign DDRAM_WE       = r_we;

endmodule

// File: tb/tb_ddr_arbiter_mister.sv
// Self-checking bench for ddr_arbiter_mister: directed and randomized transactions
// against a behavioural arbitration/memory model.
module tb_ddr_arbiter_mister;
    localparam int NCH = 4;
    localparam int AW  = 29;
    localparam int DW  = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    ch_req;
    logic [NCH-1:0]    ch_write;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_wdata;
    logic [NCH*8-1:0]  ch_be;
    logic [NCH-1:0]    ch_ready;
    logic [NCH-1:0]    ch_done;
    logic [DW-1:0]     ch_rdata;
    logic              DDRAM_CLK;
    logic              DDRAM_BUSY;
    logic [7:0]        DDRAM_BURSTCNT;
    logic [AW-1:0]     DDRAM_ADDR;
    logic [DW-1:0]     DDRAM_DOUT;
    logic              DDRAM_DOUT_READY;
    logic              DDRAM_RD;
    logic [DW-1:0]     DDRAM_DIN;
    logic [7:0]        DDRAM_BE;
    logic              DDRAM_WE;

    ddr_arbiter_mister #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .ch_req(ch_req), .ch_write(ch_write), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_be(ch_be),
        .ch_ready(ch_ready), .ch_done(ch_done), .ch_rdata(ch_rdata),
        .DDRAM_CLK(DDRAM_CLK), .DDRAM_BUSY(DDRAM_BUSY),
        .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR),
        .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
        .DDRAM_RD(DDRAM_RD), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE),
        .DDRAM_WE(DDRAM_WE)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_last;
    logic [63:0] m_rdata;
    int          got;

    function automatic int pick(logic [NCH-1:0] m);
`ifdef DDR_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= NCH; k++) begin
            int c = (m_last + k) % NCH;
            if (m[c]) return c;
        end
`else
        for (int c = 0; c < NCH; c++) if (m[c]) return c;
`endif
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields;
        for (int i = 0; i < NCH; i++) begin
            ch_write[i]            = 1'($urandom_range(0, 1));
            ch_addr[i*AW +: AW]    = AW'($urandom);
            ch_wdata[i*DW +: DW]   = {$urandom, $urandom};
            ch_be[i*8 +: 8]        = 8'($urandom);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [63:0] exp_rdata);
        chk({tag, "_ready"}, 64'(ch_ready), 64'(0));
        chk({tag, "_done"},  64'(ch_done), 64'(0));
        chk({tag, "_cmd"},   64'({DDRAM_RD, DDRAM_WE}), 64'(0));
        chk({tag, "_burst"}, 64'(DDRAM_BURSTCNT), 64'(1));
        chk({tag, "_rdata"}, ch_rdata, exp_rdata);
    endtask

    // One full transaction starting in an IDLE cycle; returns the granted channel.
    task automatic txn(input logic [NCH-1:0] mask, input int nb, input int lat,
                       input logic [DW-1:0] dout_val, output int g);
        int w;
        logic [AW-1:0] a;
        logic wr;
        w  = pick(mask);
        a  = ch_addr[w*AW +: AW];
        wr = ch_write[w];
        ch_req = mask;
        chk("idle_ready", 64'(ch_ready), 64'(0));
        step;
        g = -1;
        for (int i = 0; i < NCH; i++) if (ch_ready[i]) g = i;
        chk("grant_ready", 64'(ch_ready), 64'(1) << w);
        chk("issue_cmd", 64'({DDRAM_RD, DDRAM_WE}), 64'({!wr, wr}));
        chk("issue_addr", 64'(DDRAM_ADDR), 64'(a));
        chk("issue_burst", 64'(DDRAM_BURSTCNT), 64'(1));
        if (wr) begin
            chk("issue_din", DDRAM_DIN, ch_wdata[w*DW +: DW]);
            chk("issue_be", 64'(DDRAM_BE), 64'(ch_be[w*8 +: 8]));
        end
        m_last = w;
        DDRAM_BUSY = (nb > 0);
        for (int j = 1; j <= nb; j++) begin
            DDRAM_DOUT_READY = 1'($urandom_range(0, 1));
            DDRAM_DOUT = {$urandom, $urandom};
            step;
            chk("stall_cmd", 64'({DDRAM_RD, DDRAM_WE}), 64'({!wr, wr}));
            chk("stall_addr", 64'(DDRAM_ADDR), 64'(a));
            chk("stall_ready", 64'(ch_ready), 64'(0));
            DDRAM_BUSY = (j < nb);
        end
        DDRAM_DOUT_READY = 1'b0;
        step;
        chk("post_accept_cmd", 64'({DDRAM_RD, DDRAM_WE}), 64'(0));
        if (!wr) begin
            chk("wait_done", 64'(ch_done), 64'(0));
            for (int j = 1; j < lat; j++) begin
                step;
                chk("wait_done", 64'(ch_done), 64'(0));
            end
            DDRAM_DOUT_READY = 1'b1;
            DDRAM_DOUT = dout_val;
            step;
            DDRAM_DOUT_READY = 1'b0;
            DDRAM_DOUT = {$urandom, $urandom};
            m_rdata = dout_val;
        end
        chk("done", 64'(ch_done), 64'(1) << w);
        chk("done_rdata", ch_rdata, m_rdata);
        chk("done_ready", 64'(ch_ready), 64'(0));
        step;
        chk("after_done", 64'(ch_done), 64'(0));
        chk("rdata_hold", ch_rdata, m_rdata);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        ch_req = '0;
        step;
        step;
        reset = 1'b0;
        m_last = NCH - 1;
        m_rdata = '0;
        step;
    endtask

    initial begin
        reset = 1'b1;
        ch_req = '0;
        ch_write = '0;
        ch_addr = '0;
        ch_wdata = '0;
        ch_be = '0;
        DDRAM_BUSY = 1'b0;
        DDRAM_DOUT = '0;
        DDRAM_DOUT_READY = 1'b0;
        m_last = NCH - 1;
        m_rdata = '0;
        step;
        step;
        check_idle_outputs("reset", 64'(0));
        chk("reset_addr", 64'(DDRAM_ADDR), 64'(0));
        reset = 1'b0;
        step;
        check_idle_outputs("post_reset", 64'(0));

        // Channel 2 single write, no stall.
        rand_fields;
        ch_write[2] = 1'b1;
        ch_addr[2*AW +: AW] = 29'h0001234;
        ch_wdata[2*DW +: DW] = 64'hDEADBEEF_CAFEF00D;
        ch_be[2*8 +: 8] = 8'hFF;
        txn(4'b0100, 0, 1, 64'h0, got);
        chk("dir_write_ch", 64'(got), 64'(2));

        // Channel 0 read, 3 busy cycles, data 4 cycles after acceptance.
        rand_fields;
        ch_write[0] = 1'b0;
        txn(4'b0001, 3, 4, 64'h0123456789ABCDEF, got);
        chk("dir_read_ch", 64'(got), 64'(0));
        chk("dir_read_rdata", ch_rdata, 64'h0123456789ABCDEF);

        // Reset while waiting for read data; late data must be ignored.
        rand_fields;
        ch_write[1] = 1'b0;
        ch_req = 4'b0010;
        step;
        DDRAM_BUSY = 1'b0;
        ch_req = '0;
        step;
        step;
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("async_reset", 64'(0));
        chk("async_reset_addr", 64'(DDRAM_ADDR), 64'(0));
        step;
        reset = 1'b0;
        m_last = NCH - 1;
        m_rdata = '0;
        for (int j = 0; j < 3; j++) begin
            DDRAM_DOUT_READY = 1'b1;
            DDRAM_DOUT = {$urandom, $urandom};
            step;
            check_idle_outputs("stray_data", 64'(0));
        end
        DDRAM_DOUT_READY = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            rand_fields;
            txn(NCH'($urandom_range(1, (1 << NCH) - 1)), $urandom_range(0, 3),
                $urandom_range(1, 4), {$urandom, $urandom}, got);
        end

        // All channels requesting continuously.
        do_reset;
        for (int n = 0; n < 8; n++) begin
            rand_fields;
            txn(4'b1111, $urandom_range(0, 1), $urandom_range(1, 2), {$urandom, $urandom}, got);
`ifdef DDR_ARB_ROUND_ROBIN_EN
            chk("all_req_order", 64'(got), 64'(n % NCH));
`else
            chk("all_req_order", 64'(got), 64'(0));
`endif
        end

        // Channel 1 keeps requesting while channel 3 arrives.
        do_reset;
        rand_fields;
        txn(4'b0010, 0, 1, {$urandom, $urandom}, got);
        chk("hold_first", 64'(got), 64'(1));
        rand_fields;
        txn(4'b1010, 0, 1, {$urandom, $urandom}, got);
`ifdef DDR_ARB_ROUND_ROBIN_EN
        chk("hold_second", 64'(got), 64'(3));
`else
        chk("hold_second", 64'(got), 64'(1));
`endif
        rand_fields;
        txn(4'b1010, 0, 1, {$urandom, $urandom}, got);
        chk("hold_third", 64'(got), 64'(1));
        ch_req = '0;
        step;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
